// File: rtl/sram_pixel_writer.sv
// Purpose : writes an RGB332 pixel stream into the shared 16-bit SRAM frame buffer
//           (linear address = pixel index; byte lane chosen by index[18]).
// Latency : accept at t, SETUP t+1, WRITE t+2..t+1+WE_CYCLES, HOLD t+2+WE_CYCLES, ready again t+3+WE_CYCLES.
// Backpr. : Pix_Ready is low for the whole transaction and while the display owns the SRAM.
//
// Ports:
//   CLOCK, RESET        rising-edge clock, synchronous active-high reset
//   Pix_Data/Valid/SOF  pixel stream in; Pix_Ready is the registered accept strobe
//   Display_Active      scan-out stage owns the SRAM; no new writes start while high
//   Address_OUT/Data_Out/Data_Drive   SRAM address, write data, tristate enable for Data_IO
//   Chip_EN/Write_EN/Out_EN/LB/UB     active-low SRAM strobes
//   Bus_Busy            writer owns the bus (top-level mux select)
//   Frame_Done          one-cycle pulse after the last pixel of a frame is accepted

module sram_pixel_writer #(
    parameter int H_PIXELS  = 800,
    parameter int V_LINES   = 600,
    parameter int WE_CYCLES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [7:0]  Pix_Data,
    input  logic        Pix_Valid,
    input  logic        Pix_SOF,
    output logic        Pix_Ready,
    input  logic        Display_Active,
    output logic [18:0] Address_OUT,
    output logic [15:0] Data_Out,
    output logic        Data_Drive,
    output logic        Chip_EN,
    output logic        Write_EN,
    output logic        Out_EN,
    output logic        LB,
    output logic        UB,
    output logic        Bus_Busy,
    output logic        Frame_Done
);

    localparam int          FRAME_PIXELS = H_PIXELS * V_LINES;
    localparam logic [18:0] LAST_IDX     = 19'(FRAME_PIXELS - 1);
    localparam int          CNT_W        = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  we_cnt, we_cnt_nxt;
    logic [18:0]       pix_index, pix_index_nxt;
    logic [18:0]       acc_index;
    logic              accept;

    logic              pix_ready_nxt;
    logic [18:0]       addr_nxt;
    logic [15:0]       data_nxt;
    logic              drive_nxt;
    logic              ce_nxt;
    logic              we_nxt;
    logic              lb_nxt;
    logic              ub_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // The writer never reads the SRAM.
    assign Out_EN = 1'b1;

    always_comb begin
        state_nxt     = state;
        we_cnt_nxt    = we_cnt;
        pix_index_nxt = pix_index;
        pix_ready_nxt = 1'b0;
        addr_nxt      = Address_OUT;
        data_nxt      = Data_Out;
        drive_nxt     = Data_Drive;
        ce_nxt        = Chip_EN;
        we_nxt        = Write_EN;
        lb_nxt        = LB;
        ub_nxt        = UB;
        busy_nxt      = Bus_Busy;
        done_nxt      = 1'b0;

        // Pix_Ready is only ever high in IDLE, so this is the handshake.
        accept    = (state == ST_IDLE) && Pix_Valid && Pix_Ready;
        acc_index = Pix_SOF ? 19'd0 : pix_index;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt     = ST_SETUP;
                    addr_nxt      = acc_index;
                    data_nxt      = {Pix_Data, Pix_Data};
                    done_nxt      = (acc_index == LAST_IDX);
                    pix_index_nxt = (acc_index == LAST_IDX) ? 19'd0 : acc_index + 19'd1;
                    // Strobes are registered, so the SETUP cycle's values are loaded here.
                    busy_nxt      = 1'b1;
                    drive_nxt     = 1'b1;
                    ce_nxt        = 1'b0;
                    we_nxt        = 1'b1;
                    // Scan-out reads index[18]=1 from the upper byte lane.
                    lb_nxt        = acc_index[18];
                    ub_nxt        = ~acc_index[18];
                end else begin
                    pix_ready_nxt = ~Display_Active;
                end
            end
            ST_SETUP: begin
                state_nxt  = ST_WRITE;
                we_nxt     = 1'b0;
                we_cnt_nxt = WE_LOAD;
            end
            ST_WRITE: begin
                // Write_EN stays low; the counter covers exactly WE_CYCLES cycles.
                if (we_cnt == '0) begin
                    state_nxt = ST_HOLD;
                    we_nxt    = 1'b1;
                end else begin
                    we_cnt_nxt = we_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                state_nxt     = ST_IDLE;
                ce_nxt        = 1'b1;
                lb_nxt        = 1'b1;
                ub_nxt        = 1'b1;
                drive_nxt     = 1'b0;
                busy_nxt      = 1'b0;
                // Display_Active is only seen through this register, so a write
                // that finished under an active display cannot restart until
                // Display_Active has been low for a cycle.
                pix_ready_nxt = ~Display_Active;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            we_cnt      <= '0;
            pix_index   <= '0;
            Pix_Ready   <= 1'b0;
            Address_OUT <= '0;
            Data_Out    <= '0;
            Data_Drive  <= 1'b0;
            Chip_EN     <= 1'b1;
            Write_EN    <= 1'b1;
            LB          <= 1'b1;
            UB          <= 1'b1;
            Bus_Busy    <= 1'b0;
            Frame_Done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            we_cnt      <= we_cnt_nxt;
            pix_index   <= pix_index_nxt;
            Pix_Ready   <= pix_ready_nxt;
            Address_OUT <= addr_nxt;
            Data_Out    <= data_nxt;
            Data_Drive  <= drive_nxt;
            Chip_EN     <= ce_nxt;
            Write_EN    <= we_nxt;
            LB          <= lb_nxt;
            UB          <= ub_nxt;
            Bus_Busy    <= busy_nxt;
            Frame_Done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sram_pixel_writer.sv
module tb_sram_pixel_writer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: full-size frame, WE_CYCLES=2; index 1: 4x2 frame, WE_CYCLES=3
    logic        rst   [2];
    logic [7:0]  pdat  [2];
    logic        valid [2];
    logic        sof   [2];
    logic        da    [2];

    logic        o_rdy  [2];
    logic [18:0] o_addr [2];
    logic [15:0] o_dat  [2];
    logic        o_drv  [2];
    logic        o_ce   [2];
    logic        o_we   [2];
    logic        o_oe   [2];
    logic        o_lb   [2];
    logic        o_ub   [2];
    logic        o_busy [2];
    logic        o_fd   [2];

    sram_pixel_writer #(.H_PIXELS(800), .V_LINES(600), .WE_CYCLES(2)) u_big (
        .CLOCK(clk), .RESET(rst[0]), .Pix_Data(pdat[0]), .Pix_Valid(valid[0]),
        .Pix_SOF(sof[0]), .Pix_Ready(o_rdy[0]), .Display_Active(da[0]),
        .Address_OUT(o_addr[0]), .Data_Out(o_dat[0]), .Data_Drive(o_drv[0]),
        .Chip_EN(o_ce[0]), .Write_EN(o_we[0]), .Out_EN(o_oe[0]), .LB(o_lb[0]),
        .UB(o_ub[0]), .Bus_Busy(o_busy[0]), .Frame_Done(o_fd[0])
    );

    sram_pixel_writer #(.H_PIXELS(4), .V_LINES(2), .WE_CYCLES(3)) u_small (
        .CLOCK(clk), .RESET(rst[1]), .Pix_Data(pdat[1]), .Pix_Valid(valid[1]),
        .Pix_SOF(sof[1]), .Pix_Ready(o_rdy[1]), .Display_Active(da[1]),
        .Address_OUT(o_addr[1]), .Data_Out(o_dat[1]), .Data_Drive(o_drv[1]),
        .Chip_EN(o_ce[1]), .Write_EN(o_we[1]), .Out_EN(o_oe[1]), .LB(o_lb[1]),
        .UB(o_ub[1]), .Bus_Busy(o_busy[1]), .Frame_Done(o_fd[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each transaction is tracked by its age in cycles since
    // acceptance (1 = setup, 2..1+WE = write strobe, 2+WE = hold, 0 = idle).
    int   we_c [2] = '{2, 3};
    int   npix [2] = '{480000, 8};
    bit   mv       [2] = '{0, 0};
    int   age      [2];
    bit   exp_rdy  [2];
    int   exp_addr [2];
    int   exp_dat  [2];
    bit   exp_fd   [2];
    int   nxt_idx  [2];
    int   fd_cnt   [2] = '{0, 0};

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst[u]) begin
                mv[u] = 1; age[u] = 0; exp_rdy[u] = 0; exp_addr[u] = 0;
                exp_dat[u] = 0; exp_fd[u] = 0; nxt_idx[u] = 0;
            end else if (mv[u]) begin
                exp_fd[u] = 0;
                if (age[u] == 0 && exp_rdy[u] && valid[u]) begin
                    int idx;
                    idx          = sof[u] ? 0 : nxt_idx[u];
                    exp_addr[u]  = idx;
                    exp_dat[u]   = {16'h0, pdat[u], pdat[u]};
                    exp_fd[u]    = (idx == npix[u] - 1);
                    nxt_idx[u]   = (idx + 1) % npix[u];
                    age[u]       = 1;
                    exp_rdy[u]   = 0;
                end else if (age[u] == 0) begin
                    exp_rdy[u] = !da[u];
                end else if (age[u] == 2 + we_c[u]) begin
                    age[u]     = 0;
                    exp_rdy[u] = !da[u];
                end else begin
                    age[u]++;
                    exp_rdy[u] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mv[u]) begin
                bit busy, wr;
                busy = (age[u] >= 1) && (age[u] <= 2 + we_c[u]);
                wr   = (age[u] >= 2) && (age[u] <= 1 + we_c[u]);
                chk_eq($sformatf("u%0d_rdy", u),  o_rdy[u],  exp_rdy[u]);
                chk_eq($sformatf("u%0d_addr", u), o_addr[u], exp_addr[u]);
                chk_eq($sformatf("u%0d_data", u), o_dat[u],  exp_dat[u]);
                chk_eq($sformatf("u%0d_drv", u),  o_drv[u],  busy);
                chk_eq($sformatf("u%0d_ce", u),   o_ce[u],   !busy);
                chk_eq($sformatf("u%0d_we", u),   o_we[u],   !wr);
                chk_eq($sformatf("u%0d_oe", u),   o_oe[u],   1);
                chk_eq($sformatf("u%0d_lb", u),   o_lb[u],   busy ? exp_addr[u][18] : 1'b1);
                chk_eq($sformatf("u%0d_ub", u),   o_ub[u],   busy ? !exp_addr[u][18] : 1'b1);
                chk_eq($sformatf("u%0d_busy", u), o_busy[u], busy);
                chk_eq($sformatf("u%0d_fd", u),   o_fd[u],   exp_fd[u]);
                if (o_fd[u]) fd_cnt[u]++;
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the acceptance edge.
    task automatic send_px(input int u, input logic [7:0] d, input logic s);
        int n;
        n = 0;
        valid[u] = 1; pdat[u] = d; sof[u] = s;
        while (!o_rdy[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_eq("accept_in_time", n < 200, 1);
        @(negedge clk);
        valid[u] = 0; sof[u] = 0; pdat[u] = 8'($urandom);
    endtask

    initial begin
        #2000000;
        chk_eq("watchdog_expired", 1, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        int fd0, we_low, u, gap;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; pdat[i] = 0; valid[i] = 0; sof[i] = 0; da[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_eq("rst_rdy", o_rdy[0], 0);
        chk_eq("rst_ce", o_ce[0], 1);
        chk_eq("rst_we", o_we[0], 1);
        chk_eq("rst_addr", o_addr[0], 0);
        rst[0] = 0; rst[1] = 0;
        @(negedge clk);
        chk_eq("rdy_after_rst", o_rdy[0], 1);

        // single pixel with SOF, step through the transaction
        send_px(0, 8'hE3, 1);
        chk_eq("t1_addr", o_addr[0], 0);
        chk_eq("t1_data", o_dat[0], 16'hE3E3);
        chk_eq("t1_lb", o_lb[0], 0);
        chk_eq("t1_ub", o_ub[0], 1);
        chk_eq("t1_busy", o_busy[0], 1);
        chk_eq("t1_we", o_we[0], 1);
        @(negedge clk); chk_eq("t2_we", o_we[0], 0);
        @(negedge clk); chk_eq("t3_we", o_we[0], 0);
        @(negedge clk); chk_eq("t4_we", o_we[0], 1); chk_eq("t4_busy", o_busy[0], 1);
        @(negedge clk); chk_eq("t5_busy", o_busy[0], 0); chk_eq("t5_rdy", o_rdy[0], 1);

        // upper half of the address space selects the upper byte lane
        force u_big.pix_index = 19'h40000;
        nxt_idx[0] = 32'h40000;
        send_px(0, 8'h1C, 0);
        release u_big.pix_index;
        chk_eq("hi_addr", o_addr[0], 32'h40000);
        chk_eq("hi_lb", o_lb[0], 1);
        chk_eq("hi_ub", o_ub[0], 0);
        chk_eq("hi_data", o_dat[0], 16'h1C1C);
        repeat (5) @(negedge clk);

        // 4x2 frame: 9 pixels, SOF only on the first
        fd0 = fd_cnt[1];
        for (int i = 0; i < 9; i++) begin
            send_px(1, 8'($urandom), i == 0);
            if (i == 7) chk_eq("frame_done_pulse", o_fd[1], 1);
            if (i == 8) chk_eq("wrap_addr", o_addr[1], 0);
        end
        repeat (6) @(negedge clk);
        chk_eq("frame_done_count", fd_cnt[1] - fd0, 1);

        // display goes active during the write strobe
        send_px(0, 8'($urandom), 1);
        @(negedge clk);
        da[0] = 1; valid[0] = 1;
        we_low = (o_we[0] == 0) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_eq("da_rdy_low", o_rdy[0], 0);
            if (o_we[0] == 0) we_low++;
        end
        chk_eq("da_we_cycles", we_low, 2);
        valid[0] = 0; da[0] = 0;
        @(negedge clk);
        chk_eq("da_rdy_back", o_rdy[0], 1);

        // reset in the first write cycle abandons the write and the index
        send_px(0, 8'h77, 0);
        @(negedge clk);
        chk_eq("pre_rst_we", o_we[0], 0);
        rst[0] = 1;
        @(negedge clk);
        chk_eq("rst_mid_we", o_we[0], 1);
        chk_eq("rst_mid_drv", o_drv[0], 0);
        chk_eq("rst_mid_ce", o_ce[0], 1);
        chk_eq("rst_mid_busy", o_busy[0], 0);
        rst[0] = 0;
        @(negedge clk);
        send_px(0, 8'h5A, 0);
        chk_eq("post_rst_addr", o_addr[0], 0);
        repeat (6) @(negedge clk);

        // randomized traffic on both writers
        for (int k = 0; k < 240; k++) begin
            u   = k % 2;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                da[u]    = ($urandom_range(0, 4) == 0);
                valid[u] = ($urandom_range(0, 3) == 0);
                sof[u]   = valid[u] ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
                pdat[u]  = 8'($urandom);
                @(negedge clk);
            end
            da[u] = 0;
            send_px(u, 8'($urandom), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                da[u] = 1;
                repeat ($urandom_range(1, 6)) @(negedge clk);
                da[u] = 0;
            end
        end
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
